// File: rtl/multicycle_control_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// The master modport is the controller; the slave modport is the datapath side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       PCSource;
  logic       RegWrite;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, PCSource,
           RegWrite, ALUSrcB, ALUControl, state, illegal
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, PCSource,
           RegWrite, ALUSrcB, ALUControl, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle RV32 subset; outputs are registered alongside the state.
// Define MULTICYCLE_CONTROL_BNE_EN to add bne alongside beq.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    BR_NT    = 4'd10,
    ILLEGAL  = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       pc_source;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       illegal;
  } ctl_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t     state_q;
  state_t     nxt;
  ctl_t       ctl_q;
  logic       r_ok;
  logic       br_ok;
  logic       taken;
  logic [3:0] r_alu;

  function automatic ctl_t decode(state_t s, logic [3:0] alu);
    ctl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    case (s)
      FETCH:    begin c.mem_read = 1'b1; c.ir_write = 1'b1; end
      DECODE:   c.alu_src_b = 2'b10;
      MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMREAD:  begin c.iord = 1'b1; c.mem_read = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_control = alu; end
      EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ALUWB:    begin c.reg_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      // PC write in BRANCH is added combinationally from zero at the output.
      BRANCH:   begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_source = 1'b1; end
      BR_NT:    begin c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    r_ok = ({bus.funct3, bus.funct7_5} == 4'b0000) || ({bus.funct3, bus.funct7_5} == 4'b0001) ||
           ({bus.funct3, bus.funct7_5} == 4'b1110) || ({bus.funct3, bus.funct7_5} == 4'b1100);
`ifdef MULTICYCLE_CONTROL_BNE_EN
    br_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
    taken = (bus.funct3 == 3'b001) ? !bus.zero : bus.zero;
`else
    br_ok = (bus.funct3 == 3'b000);
    taken = bus.zero;
`endif
    case (bus.funct3)
      3'b111:  r_alu = ALU_AND;
      3'b110:  r_alu = ALU_OR;
      default: r_alu = bus.funct7_5 ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_comb begin
    nxt = ILLEGAL;
    case (state_q)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = r_ok ? EXEC_R : ILLEGAL;
          7'b0010011:             nxt = (bus.funct3 == 3'b000) ? EXEC_I : ILLEGAL;
          7'b1100011:             nxt = br_ok ? BRANCH : ILLEGAL;
          default:                nxt = ILLEGAL;
        endcase
      end
      MEMADR:   nxt = (bus.opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = FETCH;
      EXEC_R:   nxt = ALUWB;
      EXEC_I:   nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BRANCH:   nxt = taken ? FETCH : BR_NT;
      BR_NT:    nxt = FETCH;
      default:  nxt = ILLEGAL;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still Moore.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ctl_q   <= decode(FETCH, ALU_ADD);
    end else begin
      state_q <= nxt;
      ctl_q   <= decode(nxt, r_alu);
    end
  end

  assign bus.PCWrite    = ctl_q.pc_write | ((state_q == BRANCH) & taken);
  assign bus.IorD       = ctl_q.iord;
  assign bus.MemRead    = ctl_q.mem_read;
  assign bus.MemWrite   = ctl_q.mem_write;
  assign bus.IRWrite    = ctl_q.ir_write;
  assign bus.MemtoReg   = ctl_q.mem_to_reg;
  assign bus.ALUSrcA    = ctl_q.alu_src_a;
  assign bus.PCSource   = ctl_q.pc_source;
  assign bus.RegWrite   = ctl_q.reg_write;
  assign bus.ALUSrcB    = ctl_q.alu_src_b;
  assign bus.ALUControl = ctl_q.alu_control;
  assign bus.state      = state_q;
  assign bus.illegal    = ctl_q.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction vector table plus reset and ILLEGAL sequences.
// Expected control words per state are queued at stimulus time and checked each cycle.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     ir;
    logic            zero;
    int              n;
    logic [5:0][3:0] seq;
    logic [3:0]      alu;
    logic            tk;
    string           name;
  } vec_t;

  vec_t        tbl[9];
  logic [19:0] sb[$];

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,PCSource,RegWrite,ALUSrcB,ALUControl,illegal,state}
  function automatic logic [19:0] expw(logic [3:0] st, logic [3:0] alu, logic tk);
    logic [8:0] f;
    logic [1:0] b;
    logic [3:0] a;
    logic       il;
    f = '0; b = 2'b00; a = 4'b0010; il = 1'b0;
    case (st)
      4'd0:  f = 9'b0_0_1_0_1_0_0_0_0;
      4'd1:  b = 2'b10;
      4'd2:  begin f = 9'b0_0_0_0_0_0_1_0_0; b = 2'b10; end
      4'd3:  begin f = 9'b0_1_1_0_0_0_1_0_0; b = 2'b10; end
      4'd4:  begin f = 9'b1_0_0_0_0_1_0_0_1; b = 2'b01; end
      4'd5:  begin f = 9'b1_1_0_1_0_0_0_0_0; b = 2'b01; end
      4'd6:  begin f = 9'b0_0_0_0_0_0_1_0_0; a = alu; end
      4'd7:  begin f = 9'b0_0_0_0_0_0_1_0_0; b = 2'b10; end
      4'd8:  begin f = 9'b1_0_0_0_0_0_0_0_1; b = 2'b01; end
      4'd9:  begin f = {tk, 8'b0_0_0_0_0_1_1_0}; a = 4'b0110; end
      4'd10: begin f = 9'b1_0_0_0_0_0_0_0_0; b = 2'b01; end
      default: il = 1'b1;
    endcase
    return {f, b, a, il, st};
  endfunction

  function automatic logic [19:0] act();
    return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
            bus.ALUSrcA, bus.PCSource, bus.RegWrite, bus.ALUSrcB, bus.ALUControl,
            bus.illegal, bus.state};
  endfunction

  task automatic chk(input string name, input logic [19:0] a, input logic [19:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", name, a, a[3:0], e, e[3:0]);
    end
  endtask

  task automatic pop_chk(input string name);
    logic [19:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act());
    end else begin
      e = sb.pop_front();
      chk(name, act(), e);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic z);
    bus.opcode   = ir[6:0];
    bus.funct3   = ir[14:12];
    bus.funct7_5 = ir[30];
    bus.zero     = z;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at a negedge after the last listed state.
  task automatic run_vec(input vec_t v);
    drive(v.ir, v.zero);
    for (int k = 0; k < v.n; k++) sb.push_back(expw(v.seq[5-k], v.alu, v.tk));
    for (int k = 0; k < v.n; k++) begin
      pop_chk($sformatf("%s_c%0d", v.name, k));
      step();
    end
  endtask

  task automatic reset_pulse(input string name);
    reset = 1'b0;
    #1;
    chk(name, act(), expw(4'd0, 4'b0010, 1'b0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic illegal_run(input logic [31:0] ir, input logic z, input int hold, input string name);
    vec_t v;
    v = '{ir, z, 2, 24'h010000, 4'b0010, 1'b0, name};
    run_vec(v);
    // Drive a valid addi while parked to show ILLEGAL is sticky.
    drive(32'h01400193, 1'b0);
    for (int k = 0; k < hold; k++) sb.push_back(expw(4'd15, 4'b0010, 1'b0));
    for (int k = 0; k < hold; k++) begin
      pop_chk($sformatf("%s_hold%0d", name, k));
      step();
    end
    reset_pulse({name, "_reset"});
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{32'h01400193, 1'b0, 4, 24'h017800, 4'b0010, 1'b0, "addi"};
    tbl[1] = '{32'h0781A403, 1'b1, 5, 24'h012340, 4'b0010, 1'b0, "lw"};
    tbl[2] = '{32'h0081A023, 1'b0, 4, 24'h012500, 4'b0010, 1'b0, "sw"};
    tbl[3] = '{32'h002081B3, 1'b0, 4, 24'h016800, 4'b0010, 1'b0, "add"};
    tbl[4] = '{32'h402081B3, 1'b0, 4, 24'h016800, 4'b0110, 1'b0, "sub"};
    tbl[5] = '{32'h0020F1B3, 1'b1, 4, 24'h016800, 4'b0000, 1'b0, "and"};
    tbl[6] = '{32'h0020E1B3, 1'b0, 4, 24'h016800, 4'b0001, 1'b0, "or"};
    tbl[7] = '{32'h00208463, 1'b1, 3, 24'h019000, 4'b0010, 1'b1, "beq_taken"};
    tbl[8] = '{32'h00208463, 1'b0, 4, 24'h019A00, 4'b0010, 1'b0, "beq_not_taken"};

    reset = 1'b0;
    drive(32'h0, 1'b0);
    @(negedge clk);
    chk("reset_c0", act(), expw(4'd0, 4'b0010, 1'b0));
    step();
    chk("reset_c1", act(), expw(4'd0, 4'b0010, 1'b0));
    step();
    chk("reset_c2", act(), expw(4'd0, 4'b0010, 1'b0));
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset asserted asynchronously while lw sits in MEMREAD.
    drive(32'h0781A403, 1'b0);
    step();
    step();
    @(posedge clk);
    #2;
    chk("midreset_memread", act(), expw(4'd3, 4'b0010, 1'b0));
    reset = 1'b0;
    #1;
    chk("midreset_async", act(), expw(4'd0, 4'b0010, 1'b0));
    @(negedge clk);
    chk("midreset_held", act(), expw(4'd0, 4'b0010, 1'b0));
    reset = 1'b1;
    run_vec(tbl[0]);

    illegal_run(32'h0000007F, 1'b0, 10, "bad_opcode");
    illegal_run(32'h002091B3, 1'b0, 2, "bad_rtype");
    illegal_run(32'h0020C463, 1'b0, 2, "bad_branch");
    illegal_run(32'h00109193, 1'b0, 2, "bad_itype");

`ifdef MULTICYCLE_CONTROL_BNE_EN
    v = '{32'h00209463, 1'b0, 3, 24'h019000, 4'b0010, 1'b1, "bne_taken"};
    run_vec(v);
    v = '{32'h00209463, 1'b1, 4, 24'h019A00, 4'b0010, 1'b0, "bne_not_taken"};
    run_vec(v);
`else
    illegal_run(32'h00209463, 1'b0, 2, "bne_disabled");
`endif

    run_vec(tbl[1]);
    chk("final_fetch", act(), expw(4'd0, 4'b0010, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
